// File: rtl/i2c_master_writer.sv
// Write-only single-master I2C initiator: START, address+W, ACK-checked
// data bytes and STOP on open-drain SDA/SCL.
module i2c_master_writer #(
    parameter int CLK_DIV = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic       data_last,
    output logic       data_ready,
    output logic       busy,
    output logic       done,
    output logic       nack,
    inout  wire        SDA,
    inout  wire        SCL
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_WAIT,
        S_STOP
    } state_t;

    state_t        r_state;
    logic          r_pend;
    logic [DW-1:0] r_div;
    logic [1:0]    r_q;
    logic [2:0]    r_bit;
    logic [6:0]    r_addr;
    logic [7:0]    r_byte;
    logic          r_last;
    logic          r_ack;
    logic          r_sda_lo;
    logic          r_scl_lo;

    logic          w_tick;
    logic          w_bit_end;
    logic [7:0]    w_addr_byte;
    logic          w_sda_lo;
    logic          w_scl_lo;
    logic          w_sda_nxt;

    assign w_tick      = (r_div == DIV_MAX);
    assign w_bit_end   = w_tick && (r_q == 2'd3);
    assign w_addr_byte = {r_addr, 1'b0};

    assign SDA = r_sda_lo ? 1'b0 : 1'bz;
    assign SCL = r_scl_lo ? 1'b0 : 1'bz;

    always_comb begin
        w_scl_lo = 1'b0;
        w_sda_lo = 1'b0;
        unique case (r_state)
            S_IDLE: ;
            S_START: begin
                w_sda_lo = r_q[1];
                w_scl_lo = (r_q == 2'd3);
            end
            S_ADDR: begin
                w_scl_lo = !r_q[1];
                w_sda_lo = !w_addr_byte[r_bit];
            end
            S_DATA: begin
                w_scl_lo = !r_q[1];
                w_sda_lo = !r_byte[r_bit];
            end
            S_ADDR_ACK, S_DATA_ACK: begin
                w_scl_lo = !r_q[1];
            end
            S_WAIT: begin
                w_scl_lo = 1'b1;
                w_sda_lo = 1'b1;
            end
            S_STOP: begin
                w_scl_lo = !r_q[1];
                w_sda_lo = (r_q != 2'd3);
            end
            default: ;
        endcase
        // Hold SDA one extra cycle while SCL falls so it never moves with SCL high
        w_sda_nxt = (w_scl_lo && !r_scl_lo) ? r_sda_lo : w_sda_lo;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_pend     <= 1'b0;
            r_div      <= '0;
            r_q        <= 2'd0;
            r_bit      <= 3'd0;
            r_addr     <= 7'd0;
            r_byte     <= 8'd0;
            r_last     <= 1'b0;
            r_ack      <= 1'b0;
            r_sda_lo   <= 1'b0;
            r_scl_lo   <= 1'b0;
            data_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            nack       <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            done       <= 1'b0;
            r_sda_lo   <= w_sda_nxt;
            r_scl_lo   <= w_scl_lo;
            if (r_state == S_IDLE) begin
                r_div <= '0;
                r_q   <= 2'd0;
            end else begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
                if (w_tick) r_q <= r_q + 2'd1;
            end
            if (w_tick && r_q == 2'd2) r_ack <= SDA;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr  <= addr;
                        nack    <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        if (data_valid) begin
                            r_byte     <= data_in;
                            r_last     <= data_last;
                            data_ready <= 1'b1;
                            r_bit      <= 3'd7;
                            r_state    <= S_ADDR;
                        end else begin
                            r_pend  <= 1'b0;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_ADDR: begin
                    if (w_bit_end) begin
                        if (r_bit == 3'd0) r_state <= S_ADDR_ACK;
                        else r_bit <= r_bit - 3'd1;
                    end
                end
                S_ADDR_ACK: begin
                    if (w_bit_end) begin
                        if (r_ack) begin
                            nack    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit   <= 3'd7;
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit == 3'd0) r_state <= S_DATA_ACK;
                        else r_bit <= r_bit - 3'd1;
                    end
                end
                S_DATA_ACK: begin
                    if (w_bit_end) begin
                        if (r_ack) begin
                            nack    <= 1'b1;
                            r_state <= S_STOP;
                        end else if (r_last) begin
                            r_state <= S_STOP;
                        end else if (data_valid) begin
                            r_byte     <= data_in;
                            r_last     <= data_last;
                            data_ready <= 1'b1;
                            r_bit      <= 3'd7;
                            r_state    <= S_DATA;
                        end else begin
                            r_pend  <= 1'b1;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_div <= '0;
                    r_q   <= 2'd0;
                    if (data_valid) begin
                        r_byte     <= data_in;
                        r_last     <= data_last;
                        data_ready <= 1'b1;
                        r_bit      <= 3'd7;
                        r_state    <= r_pend ? S_DATA : S_ADDR;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
